frame_buffer_controller: RTL

Sequencer and arbiter for the single-port `frame_buffer` row store. It accepts a raster-order pixel write stream and random-access read requests from the edge-detection window logic, and grants at most one frame buffer access per cycle. It owns the circular write pointer (column/row), issues registered commands to the frame buffer and returns read data with fixed latency. It sits between the colorspace converter output and the 3x3 kernel stage.

---
 rtl/frame_buffer_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_controller.sv
// Sequencer and arbiter for the single-port frame_buffer row store.
// Define FB_CTRL_WRITE_PRIORITY_EN for fixed write priority (default: round-robin).
module frame_buffer_controller #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 3,
  parameter int P_PIXEL_DEPTH = 24,
  localparam int CW = (P_COLUMNS > 1) ? $clog2(P_COLUMNS) : 1,
  localparam int RW = (P_ROWS > 1) ? $clog2(P_ROWS) : 1
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_ENABLE,
  input  logic                     I_FRAME_START,
  input  logic                     I_WR_VALID,
  input  logic [P_PIXEL_DEPTH-1:0] I_WR_PIXEL,
  output logic                     O_WR_READY,
  input  logic                     I_RD_REQ,
  input  logic [CW-1:0]            I_RD_COL,
  input  logic [RW-1:0]            I_RD_ROW,
  output logic                     O_RD_GNT,
  output logic                     O_RD_VALID,
  output logic [P_PIXEL_DEPTH-1:0] O_RD_PIXEL,
  output logic                     O_ROW_DONE,
  output logic [RW-1:0]            O_WR_ROW,
  output logic [RW:0]              O_ROWS_VALID,
  output logic                     O_FB_ENABLE,
  output logic                     O_FB_WRITE_ENABLE,
  output logic                     O_FB_READ_ENABLE,
  output logic [CW-1:0]            O_FB_COL,
  output logic [RW-1:0]            O_FB_ROW,
  output logic [P_PIXEL_DEPTH-1:0] O_FB_PIXEL,
  input  logic [P_PIXEL_DEPTH-1:0] I_FB_PIXEL
);

  localparam logic [CW-1:0] COL_LAST  = CW'(P_COLUMNS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(P_ROWS - 1);
  localparam logic [RW:0]   ROWS_FULL = (RW+1)'(P_ROWS);

  logic          wr_gnt;
  logic          rd_gnt;
  logic [CW-1:0] wr_col;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic [RW:0]   rv_cur;
  logic          row_end;
  logic          rd_p1;
  logic          rd_p2;

  assign O_FB_ENABLE = I_ENABLE;
  assign O_WR_READY  = wr_gnt;
  assign O_RD_GNT    = rd_gnt;

`ifdef FB_CTRL_WRITE_PRIORITY_EN
  // Write always wins; reads only fill cycles with no write offered
  always_comb begin
    wr_gnt = I_ENABLE & I_WR_VALID;
    rd_gnt = I_ENABLE & I_RD_REQ & ~I_WR_VALID;
  end
`else
  logic last_grant;

  // Round-robin: under contention the side not granted last wins
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (I_ENABLE) begin
      if (I_WR_VALID && I_RD_REQ) begin
        wr_gnt = ~last_grant;
        rd_gnt = last_grant;
      end else begin
        wr_gnt = I_WR_VALID;
        rd_gnt = I_RD_REQ;
      end
    end
  end

  // Remember the previous winner (1 = write, 0 = read)
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      last_grant <= 1'b0;
    end else if (wr_gnt) begin
      last_grant <= 1'b1;
    end else if (rd_gnt) begin
      last_grant <= 1'b0;
    end
  end
`endif

  // Frame start zeroes the pointer before a same-cycle write uses it
  always_comb begin
    col_cur = I_FRAME_START ? '0 : wr_col;
    row_cur = I_FRAME_START ? '0 : O_WR_ROW;
    rv_cur  = I_FRAME_START ? '0 : O_ROWS_VALID;
    row_end = wr_gnt && (col_cur == COL_LAST);
  end

  // Circular write pointer and completed-row count
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      wr_col       <= '0;
      O_WR_ROW     <= '0;
      O_ROWS_VALID <= '0;
      O_ROW_DONE   <= 1'b0;
    end else if (!I_ENABLE) begin
      O_ROW_DONE <= 1'b0;
    end else begin
      O_ROW_DONE   <= row_end;
      wr_col       <= col_cur;
      O_WR_ROW     <= row_cur;
      O_ROWS_VALID <= rv_cur;
      if (row_end) begin
        wr_col   <= '0;
        O_WR_ROW <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
        if (rv_cur != ROWS_FULL) begin
          O_ROWS_VALID <= rv_cur + 1'b1;
        end
      end else if (wr_gnt) begin
        wr_col <= col_cur + 1'b1;
      end
    end
  end

  // Registered frame buffer command; address and data hold when idle
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      O_FB_WRITE_ENABLE <= 1'b0;
      O_FB_READ_ENABLE  <= 1'b0;
      O_FB_COL          <= '0;
      O_FB_ROW          <= '0;
      O_FB_PIXEL        <= '0;
    end else if (I_ENABLE) begin
      O_FB_WRITE_ENABLE <= wr_gnt;
      O_FB_READ_ENABLE  <= rd_gnt;
      if (wr_gnt) begin
        O_FB_COL   <= col_cur;
        O_FB_ROW   <= row_cur;
        O_FB_PIXEL <= I_WR_PIXEL;
      end else if (rd_gnt) begin
        O_FB_COL <= I_RD_COL;
        O_FB_ROW <= I_RD_ROW;
      end
    end
  end

  // Two-stage read return; frozen while disabled
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
      O_RD_VALID <= 1'b0;
      O_RD_PIXEL <= '0;
    end else if (!I_ENABLE) begin
      O_RD_VALID <= 1'b0;
    end else begin
      rd_p1      <= rd_gnt;
      rd_p2      <= rd_p1;
      O_RD_VALID <= rd_p2;
      if (rd_p2) begin
        O_RD_PIXEL <= I_FB_PIXEL;
      end
    end
  end

endmodule
